// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared period counter (edge- or center-aligned),
// double-buffered per-channel duty with compare values committed at period boundaries.
module pwm_multi_ch #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 21,
  parameter  int DUTY_W = 10,
  localparam int WCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_center_mode,
  input  logic [CNT_W-1:0]  i_period,
  input  logic              i_wr_en,
  input  logic [WCH_W-1:0]  i_wr_ch,
  input  logic [DUTY_W-1:0] i_wr_duty,
  input  logic [NUM_CH-1:0] i_polarity,
  output logic [NUM_CH-1:0] o_pwm_out,
  output logic              o_period_start,
  output logic              o_update_pending
);

  localparam int PROD_W = CNT_W + DUTY_W;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_dir;
  logic [CNT_W-1:0]  r_p_act;
  logic              r_mode_act;
  logic [DUTY_W-1:0] r_shadow [NUM_CH];
  logic [CNT_W-1:0]  r_cmp    [NUM_CH];
  logic              r_pend;
  logic [NUM_CH-1:0] r_pwm;
  logic              r_period_start;

  logic [CNT_W-1:0]  w_p_eff;
  logic              w_last;
  logic              w_boundary;
  logic              w_reload;
  logic              w_wr_ok;
  logic              w_wr_any;
  logic [NUM_CH-1:0] w_wr_hit;
  logic [CNT_W-1:0]  w_cmp_new [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_dir_next;

  // Periods of 0 and 1 cannot produce a waveform, so they run as 2.
  assign w_p_eff    = (i_period < CNT_W'(2)) ? CNT_W'(2) : i_period;
  assign w_last     = (r_cnt == r_p_act - CNT_W'(1));
  assign w_boundary = r_mode_act ? (r_dir && (r_cnt == '0)) : w_last;
  assign w_reload   = !i_enable || w_boundary;
  assign w_wr_ok    = ({1'b0, i_wr_ch} < (WCH_W + 1)'(NUM_CH));
  assign w_wr_any   = i_wr_en && w_wr_ok;

  // Center mode repeats the top count once (dir flips) so each half-sweep is p_act cycles.
  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir;
    if (w_reload) begin
      w_cnt_next = '0;
      w_dir_next = 1'b0;
    end else if (!r_mode_act) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end else if (!r_dir) begin
      if (w_last) w_dir_next = 1'b1;
      else        w_cnt_next = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt          <= '0;
      r_dir          <= 1'b0;
      r_p_act        <= CNT_W'(2);
      r_mode_act     <= 1'b0;
      r_pend         <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_dir          <= w_dir_next;
      r_period_start <= i_enable && w_boundary;
      if (w_reload) begin
        r_p_act    <= w_p_eff;
        r_mode_act <= i_center_mode;
      end
      // A write landing on a reload cycle survives it and waits for the next one.
      if (w_wr_any)      r_pend <= 1'b1;
      else if (w_reload) r_pend <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PROD_W-1:0] w_prod;

      assign w_wr_hit[gi]  = w_wr_any && (i_wr_ch == WCH_W'(gi));
      assign w_prod        = PROD_W'(w_p_eff) * PROD_W'(r_shadow[gi]);
      assign w_cmp_new[gi] = CNT_W'(w_prod >> DUTY_W);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_shadow[gi] <= '0;
          r_cmp[gi]    <= '0;
          r_pwm[gi]    <= 1'b0;
        end else begin
          if (w_wr_hit[gi]) r_shadow[gi] <= i_wr_duty;
          if (w_reload)     r_cmp[gi]    <= w_cmp_new[gi];
          if (!i_enable) r_pwm[gi] <= i_polarity[gi];
          else           r_pwm[gi] <= (r_cnt < r_cmp[gi]) ^ i_polarity[gi];
        end
      end
    end
  endgenerate

  assign o_pwm_out        = r_pwm;
  assign o_period_start   = r_period_start;
  assign o_update_pending = r_pend;

endmodule
